// File: rtl/piso_rr_arbiter_if.sv
// Handshake bundle between NUM_REQ upstream requesters and the shared serializer input.
// The arbiter sits on the slave side; producers and serializer together form the master side.
interface piso_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 2
);
    logic [NUM_REQ-1:0]            req_vld;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_dat;
    logic [NUM_REQ-1:0]            req_rdy;
    logic                          out_vld;
    logic                          out_last;
    logic [DATA_WIDTH-1:0]         out_dat;
    logic [ID_WIDTH-1:0]           out_id;
    logic                          out_rdy;
    logic                          busy;

    modport master (
        output req_vld, req_last, req_dat, out_rdy,
        input  req_rdy, out_vld, out_last, out_dat, out_id, busy
    );

    modport slave (
        input  req_vld, req_last, req_dat, out_rdy,
        output req_rdy, out_vld, out_last, out_dat, out_id, busy
    );
endinterface

// File: rtl/piso_rr_arbiter.sv
// Packet-granular round-robin arbiter feeding one registered output beat to the PISO.
// A grant is held from the first beat until the owner's LAST beat is accepted.
module piso_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    piso_rr_arbiter_if.slave  bus
);

    typedef enum logic {IDLE, LOCK} state_t;

    localparam logic [ID_WIDTH:0] NREQ_W = (ID_WIDTH+1)'(NUM_REQ);

    state_t                  state_q;
    logic [ID_WIDTH-1:0]     ptr_q;
    logic [ID_WIDTH-1:0]     ptr_d;
    logic [ID_WIDTH-1:0]     owner_q;
    logic                    out_vld_q;
    logic                    out_last_q;
    logic [DATA_WIDTH-1:0]   out_dat_q;
    logic [ID_WIDTH-1:0]     out_id_q;

    logic [DATA_WIDTH-1:0]   dat_arr [NUM_REQ];
    logic [ID_WIDTH-1:0]     sel;
    logic [ID_WIDTH-1:0]     acc_idx;
    logic [NUM_REQ-1:0]      rdy;
    logic                    load_ok;
    logic                    accept;

    function automatic logic [ID_WIDTH-1:0] wrapAdd(input logic [ID_WIDTH-1:0] base, input int off);
        logic [ID_WIDTH:0] sum;
        sum = {1'b0, base} + (ID_WIDTH+1)'(off);
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        return sum[ID_WIDTH-1:0];
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign dat_arr[g] = bus.req_dat[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from the farthest candidate down so the one nearest ptr overrides.
    always_comb begin
        sel = ptr_q;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            if (bus.req_vld[wrapAdd(ptr_q, k)]) sel = wrapAdd(ptr_q, k);
        end
    end

    assign load_ok = !out_vld_q | bus.out_rdy;
    assign acc_idx = (state_q == LOCK) ? owner_q : sel;
    assign ptr_d   = wrapAdd(acc_idx, 1);

    always_comb begin
        rdy = '0;
        if (!rst_i && load_ok && ((state_q == LOCK) || (|bus.req_vld))) rdy[acc_idx] = 1'b1;
    end

    assign accept = |(bus.req_vld & rdy);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_dat_q  <= '0;
            out_id_q   <= '0;
        end else if (accept) begin
            out_vld_q  <= 1'b1;
            out_dat_q  <= dat_arr[acc_idx];
            out_last_q <= bus.req_last[acc_idx];
            out_id_q   <= acc_idx;
            if (bus.req_last[acc_idx]) begin
                state_q <= IDLE;
                ptr_q   <= ptr_d;
            end else begin
                state_q <= LOCK;
                owner_q <= acc_idx;
            end
        end else if (bus.out_rdy) begin
            out_vld_q <= 1'b0;
        end
    end

    assign bus.req_rdy  = rdy;
    assign bus.out_vld  = out_vld_q;
    assign bus.out_last = out_last_q;
    assign bus.out_dat  = out_dat_q;
    assign bus.out_id   = out_id_q;
    assign bus.busy     = (state_q == LOCK) | out_vld_q;

endmodule

// File: tb/tb_piso_rr_arbiter.sv
// Directed and randomized bench for piso_rr_arbiter against a packet-level reference model.
module tb_piso_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    int              mPtr;
    int              mOwner;
    bit              mLock;
    bit              mOutVld;
    bit              mOutLast;
    logic [DW-1:0]   mOutDat;
    int              mOutId;
    logic [N-1:0]    lastAcc;
    int              remaining [N];

    always #5 clk = ~clk;

    piso_rr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    piso_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setReq(input int i, input bit v, input bit l, input logic [DW-1:0] d);
        bus.req_vld[i]           = v;
        bus.req_last[i]          = l;
        bus.req_dat[i*DW +: DW]  = d;
    endtask

    task automatic clearInputs();
        for (int i = 0; i < N; i++) setReq(i, 1'b0, 1'b0, '0);
    endtask

    task automatic modelReset();
        mPtr = 0; mOwner = 0; mLock = 1'b0;
        mOutVld = 1'b0; mOutLast = 1'b0; mOutDat = '0; mOutId = 0;
    endtask

    // Grant rule: locked owner only, else first valid requester at or after ptr.
    function automatic logic [N-1:0] modelRdy();
        logic [N-1:0] r;
        bit           loadOk;
        r = '0;
        loadOk = !mOutVld || bus.out_rdy;
        if (rst || !loadOk) return r;
        if (mLock) begin
            r[mOwner] = 1'b1;
            return r;
        end
        for (int j = 0; j < N; j++) begin
            int c;
            c = (mPtr + j) % N;
            if (bus.req_vld[c]) begin
                r[c] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic checkAll(input string phase);
        checkOutput({phase, ".vld"},  DW'(bus.out_vld),  DW'(mOutVld));
        checkOutput({phase, ".dat"},  bus.out_dat,       mOutDat);
        checkOutput({phase, ".last"}, DW'(bus.out_last), DW'(mOutLast));
        checkOutput({phase, ".id"},   DW'(bus.out_id),   DW'(mOutId));
        checkOutput({phase, ".busy"}, DW'(bus.busy),     DW'(mLock | mOutVld));
    endtask

    // One clock: check grants before the edge, advance the model, check outputs after it.
    task automatic applyStimulus(input string phase);
        logic [N-1:0] expRdy;
        @(negedge clk);
        expRdy = modelRdy();
        checkOutput({phase, ".rdy"}, DW'(bus.req_rdy), DW'(expRdy));
        @(posedge clk);
        lastAcc = bus.req_vld & expRdy;
        if (lastAcc != '0) begin
            for (int i = 0; i < N; i++) begin
                if (lastAcc[i]) begin
                    mOutVld  = 1'b1;
                    mOutDat  = bus.req_dat[i*DW +: DW];
                    mOutLast = bus.req_last[i];
                    mOutId   = i;
                    if (bus.req_last[i]) begin
                        mLock = 1'b0;
                        mPtr  = (i + 1) % N;
                    end else begin
                        mLock  = 1'b1;
                        mOwner = i;
                    end
                end
            end
        end else if (bus.out_rdy) begin
            mOutVld = 1'b0;
        end
        #1;
        checkAll(phase);
    endtask

    task automatic applyReset(input string phase);
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput({phase, ".rdy"}, DW'(bus.req_rdy), '0);
        checkAll(phase);
        clearInputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Requesters follow the protocol: payload changes only when idle or just accepted.
    task automatic randomizeInputs();
        for (int i = 0; i < N; i++) begin
            bit holding;
            holding = bus.req_vld[i] && !lastAcc[i];
            if (bus.req_vld[i] && lastAcc[i]) remaining[i]--;
            if (!holding) begin
                if (remaining[i] == 0 && $urandom_range(0, 2) == 0) remaining[i] = $urandom_range(1, 4);
                if (remaining[i] > 0 && $urandom_range(0, 3) != 0)
                    setReq(i, 1'b1, remaining[i] == 1, {$urandom, $urandom});
                else
                    setReq(i, 1'b0, 1'b0, '0);
            end
        end
        bus.out_rdy = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        int beat;
        clearInputs();
        bus.out_rdy = 1'b1;
        lastAcc = '0;
        modelReset();
        for (int i = 0; i < N; i++) remaining[i] = 0;

        applyReset("reset");

        setReq(2, 1'b1, 1'b1, 64'hA5);
        applyStimulus("single");
        checkOutput("single.id2",  DW'(bus.out_id), 64'd2);
        checkOutput("single.a5",   bus.out_dat,     64'hA5);
        setReq(2, 1'b0, 1'b0, '0);
        applyStimulus("single.drain");

        for (int i = 0; i < N; i++) setReq(i, 1'b1, 1'b1, 64'h10 + DW'(i));
        for (int c = 0; c < 6; c++) begin
            applyStimulus("rr");
            checkOutput("rr.seq", DW'(bus.out_id), DW'((3 + c) % 4));
        end

        clearInputs();
        setReq(0, 1'b1, 1'b1, 64'hB0);
        beat = 0;
        setReq(1, 1'b1, 1'b0, 64'hC0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus("lock");
            checkOutput("lock.id",   DW'(bus.out_id),   64'd1);
            checkOutput("lock.last", DW'(bus.out_last), DW'(c == 2));
            if (c < 2) checkOutput("lock.rdy0", DW'(bus.req_rdy[0]), '0);
            beat++;
            setReq(1, beat < 3, beat == 2, 64'hC0 + DW'(beat));
        end
        applyStimulus("lock.next");
        checkOutput("lock.next.id", DW'(bus.out_id), 64'd0);

        clearInputs();
        setReq(2, 1'b1, 1'b1, 64'hE2);
        bus.out_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus("stall");
            checkOutput("stall.hold", bus.out_dat, 64'hB0);
        end
        bus.out_rdy = 1'b1;
        applyStimulus("stall.release");
        checkOutput("stall.nobubble", bus.out_dat, 64'hE2);
        clearInputs();
        applyStimulus("stall.drain");

        setReq(3, 1'b1, 1'b0, 64'hD0);
        applyStimulus("gap.start");
        setReq(3, 1'b0, 1'b0, 64'hD0);
        setReq(0, 1'b1, 1'b1, 64'h70);
        setReq(1, 1'b1, 1'b1, 64'h71);
        for (int c = 0; c < 4; c++) begin
            applyStimulus("gap");
            checkOutput("gap.busy", DW'(bus.busy),    64'd1);
            checkOutput("gap.idle", DW'(bus.out_vld), 64'd0);
        end
        setReq(3, 1'b1, 1'b0, 64'hD1);
        applyStimulus("gap.resume");
        setReq(3, 1'b1, 1'b1, 64'hD2);
        applyStimulus("gap.end");
        checkOutput("gap.end.last", DW'(bus.out_last), 64'd1);
        setReq(3, 1'b0, 1'b0, '0);
        applyStimulus("gap.wrap");
        checkOutput("gap.wrap.id", DW'(bus.out_id), 64'd0);
        clearInputs();
        applyStimulus("gap.drain");

        setReq(2, 1'b1, 1'b0, 64'hF0);
        applyStimulus("mid");
        #2;
        applyReset("midrst");
        setReq(1, 1'b1, 1'b1, 64'h81);
        setReq(3, 1'b1, 1'b1, 64'h83);
        applyStimulus("restart");
        checkOutput("restart.id", DW'(bus.out_id), 64'd1);
        clearInputs();
        applyStimulus("restart.drain");

        lastAcc = '0;
        for (int c = 0; c < 400; c++) begin
            randomizeInputs();
            applyStimulus("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
